// File: rtl/corr_fold_serial.sv
// corr_fold_serial: limb-serial correction add.
// out_data = in_data + corr[in_m] (mod 2**W), processed LIMB bits per cycle,
// with corr[] held in a runtime-writable table of 2**K W-bit entries.
// Optional feature macro: CORR_FOLD_SUBTRACT_EN (in_sub selects in_data - corr).
module corr_fold_serial #(
  parameter int W    = 1506,
  parameter int K    = 3,
  parameter int LIMB = 64,
  localparam int NLIMB = (W + LIMB - 1) / LIMB,
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tbl_we,
  input  logic [K-1:0]    tbl_idx,
  input  logic [CW-1:0]   tbl_limb,
  input  logic [LIMB-1:0] tbl_wdata,
  output logic            tbl_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [K-1:0]    in_m,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_carry
);

  localparam int LASTW = W - (NLIMB - 1) * LIMB;
  localparam int WP    = NLIMB * LIMB;
  localparam logic [LIMB-1:0] LASTMASK = {LIMB{1'b1}} >> (LIMB - LASTW);

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [LIMB-1:0] r_tbl [2**K][NLIMB];
  logic            r_err;
  logic [WP-1:0]   r_a;
  logic [WP-1:0]   r_res;
  logic [K-1:0]    r_m;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_ocarry;

  logic            w_last;
  logic            w_wr_ok;
  logic [LIMB-1:0] w_wmask;
  logic [LIMB-1:0] w_b;
  logic [LIMB:0]   w_full;
  logic            w_cout;
  logic [LIMB-1:0] w_limb;
  logic [WP-W:0]   w_unused_res;

`ifdef CORR_FOLD_SUBTRACT_EN
  logic            r_sub;
`else
  logic            w_unused_sub;
  assign w_unused_sub = in_sub;
`endif

  assign w_last  = (r_cnt == CW'(NLIMB - 1));
  assign w_wr_ok = (r_state == IDLE) && (int'(tbl_limb) < NLIMB);
  // Bits above the true width of the last limb are never stored, so the
  // padded datapath above bit W-1 always stays zero.
  assign w_wmask = (int'(tbl_limb) == NLIMB - 1) ? LASTMASK : '1;
  assign w_b     = r_tbl[r_m][r_cnt];

  // Current limb sum (or difference), one bit wider to expose carry/borrow.
  always_comb begin
    w_full = {1'b0, r_a[LIMB-1:0]} + {1'b0, w_b} + {{LIMB{1'b0}}, r_carry};
`ifdef CORR_FOLD_SUBTRACT_EN
    if (r_sub) begin
      w_full = {1'b0, r_a[LIMB-1:0]} - {1'b0, w_b} - {{LIMB{1'b0}}, r_carry};
    end
`endif
  end

  // Last limb: carry/borrow comes from bit W-1's successor, not the limb edge.
  assign w_cout = w_last ? w_full[LASTW] : w_full[LIMB];
  assign w_limb = w_last ? (w_full[LIMB-1:0] & LASTMASK) : w_full[LIMB-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = ADD;
      ADD:     if (w_last)    w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Correction table writes and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < 2**K; e++) begin
        for (int unsigned l = 0; l < NLIMB; l++) begin
          r_tbl[e][l] <= '0;
        end
      end
      r_err <= 1'b0;
    end else if (tbl_we) begin
      if (w_wr_ok) r_tbl[tbl_idx][tbl_limb] <= tbl_wdata & w_wmask;
      else         r_err <= 1'b1;
    end
  end

  // Operand capture and limb-serial accumulate; result limbs shift in from the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_res    <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_ocarry <= 1'b0;
`ifdef CORR_FOLD_SUBTRACT_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= WP'(in_data);
            r_m     <= in_m;
            r_cnt   <= '0;
            r_carry <= 1'b0;
`ifdef CORR_FOLD_SUBTRACT_EN
            r_sub   <= in_sub;
`endif
          end
        end
        ADD: begin
          r_a     <= r_a >> LIMB;
          r_res   <= WP'({w_limb, r_res} >> LIMB);
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_ocarry <= w_cout;
        end
        default: ;
      endcase
    end
  end

  assign w_unused_res = r_res[WP-1:W-1];

  assign tbl_err   = r_err;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_res[W-1:0];
  assign out_carry = r_ocarry;

endmodule

// File: doc/corr_fold_serial.md
Name: corr_fold_serial

Overview:
- Limb-serial correction-add unit for the wide modular reduction path.
- Accepts a W-bit partial result plus a K-bit overflow index M, looks up a correction constant corr[M] from a runtime-programmable table, and adds it LIMB bits per cycle.
- Replaces fixed-width, hard-coded correction LUTs, so one block serves any modulus and width.
- Sits between the multiplier's fold stage and the final conditional-subtract stage.

Parameters:
- W, 1506, operand and correction-constant width in bits.
- K, 3, overflow index width; the table holds 2**K entries.
- LIMB, 64, bits added per cycle. NLIMB = ceil(W/LIMB); the last limb is W-(NLIMB-1)*LIMB bits wide.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- tbl_we  in  1  table write strobe
- tbl_idx  in  K  table entry select
- tbl_limb  in  clog2(NLIMB)  limb select within the entry
- tbl_wdata  in  LIMB  write data; bits above the last limb's width are ignored
- tbl_err  out  1  sticky: write dropped while busy, or tbl_limb >= NLIMB
- in_valid  in  1  operand valid
- in_ready  out  1  high only in IDLE
- in_data  in  W  partial result
- in_m  in  K  correction index
- in_sub  in  1  subtract mode (used only with the optional feature)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  W  sum (or difference) mod 2**W
- out_carry  out  1  carry out of bit W-1 (borrow in subtract mode)

Behaviour:
- Reset (async, active-high):
  - state=IDLE; in_ready=1; out_valid=0; out_data=0; out_carry=0; tbl_err=0.
  - All table entries = 0.
  - Reset mid-operation abandons the operation; no partial result is ever presented.
- FSM states are IDLE, ADD and HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: capture in_data, in_m and in_sub; clear carry; limb counter=0; go to ADD.
- ADD:
  - Each cycle, limb i = in_data limb i + corr[in_m] limb i + carry.
  - The result limb is written into out_data; the carry is registered.
  - Limb i is registered at edge E0+1+i.
  - After limb NLIMB-1 at edge E0+NLIMB: out_carry = final carry; out_valid=1; go to HOLD.
  - Latency is exactly NLIMB cycles from accept to out_valid (24 at defaults).
  - The last limb is masked to its true width. The carry is taken from bit W-1, not from the LIMB boundary.
- HOLD:
  - out_data and out_carry remain stable while out_valid=1.
  - On out_valid&&out_ready: out_valid=0; go to IDLE.
  - in_ready returns to 1 on the following cycle. There is no same-cycle turnaround, so the maximum throughput is one operation per NLIMB+2 cycles.
- Table writes:
  - A write is accepted only in IDLE and only when tbl_limb < NLIMB; it updates entry[tbl_idx] limb[tbl_limb] at the edge.
  - A write in ADD or HOLD, or with tbl_limb >= NLIMB, is dropped and sets tbl_err. tbl_err clears only on rst.
  - A write and an input accept in the same IDLE cycle: the write lands first. The operation uses the written value only if that limb is read in a later cycle; it always is, since limb 0 is read at E0+1.
- in_m=0 uses entry 0 like any other index; it is not forced to zero.
- Inputs are ignored while in_ready=0.
- in_data is not required to be held after acceptance.

Optional Feature:
- Macro: CORR_FOLD_SUBTRACT_EN.
- Defined:
  - in_sub captured as 1 selects out_data = in_data - corr[in_m] mod 2**W, computed limb-serially with borrow.
  - out_carry = 1 if a borrow occurred (in_data < corr). Latency is unchanged.
- Undefined:
  - in_sub is ignored; the unit always adds.
  - The subtract datapath is absent.

Test Plan:
- Defaults; after reset, write entry 1 limb 23 = 0x200000000 (bit 1505); in_data=0, in_m=1 -> out_valid exactly 24 cycles after accept; out_data = 2**1505; out_carry=0.
- W=16, LIMB=4, K=2; entry 2 = 0x0001; in_data=0xFFFF, in_m=2 -> out_data=0x0000, out_carry=1. This shows carry ripple across all 4 limbs.
- W=10, LIMB=4 (last limb 2 bits); entry 3 = 0x3FF; in_data=0x001 -> out_data=0x000, out_carry=1. Carry is taken from bit 9.
- Hold and backpressure: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, an in_valid pulse is ignored. Then out_ready=1 -> out_valid drops and in_ready rises the next cycle.
- Write during ADD to the active entry -> the result uses the old value and tbl_err=1. Write with tbl_limb=NLIMB in IDLE -> dropped and tbl_err=1. rst mid-ADD -> out_valid=0, tbl_err=0, table zeroed.
- CORR_FOLD_SUBTRACT_EN defined; W=16, LIMB=4; entry 1 = 0x0005; in_sub=1, in_data=0x0003 -> out_data=0xFFFE, out_carry=1. in_data=0x0008 -> out_data=0x0003, out_carry=0.
